// File: rtl/mux4to1_pkg.sv
// Shared select encodings for the 4:1 selector family.
// Every code maps to a real source, so decoders need no illegal-code branch.
package mux4to1_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_IN1 = 2'b00;
  localparam sel_t SEL_IN2 = 2'b01;
  localparam sel_t SEL_IN3 = 2'b10;
  localparam sel_t SEL_IN4 = 2'b11;

endpackage

// File: rtl/mux4to1_comb.sv
// Combinational 4:1 word select.
// Feeds both the bypass output and the output register of mux4to1_reg.
module mux4to1_comb
  import mux4to1_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  sel_t             sel,
  output logic [WIDTH-1:0] out
);

  // The default assignment only keeps the block latch-free; all four codes are decoded.
  always_comb begin
    out = in1;
    unique case (sel)
      SEL_IN1: out = in1;
      SEL_IN2: out = in2;
      SEL_IN3: out = in3;
      SEL_IN4: out = in4;
    endcase
  end

endmodule

// File: rtl/mux4to1_reg.sv
// 4-input WIDTH-bit selector with a one-cycle registered output and a zero-latency bypass.
// out and out_sel hold across idle cycles; only out_valid drops.
module mux4to1_reg
  import mux4to1_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  sel_t             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output sel_t             out_sel,
  output logic [WIDTH-1:0] out_comb
);

  mux4to1_comb #(
    .WIDTH(WIDTH)
  ) u_select (
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .in4(in4),
    .sel(sel),
    .out(out_comb)
  );

  // Reset wins over in_valid, so an in-flight word is dropped on a reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_sel   <= SEL_IN1;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out       <= out_comb;
      out_sel   <= sel;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4to1_reg.sv
// Scoreboard bench for mux4to1_reg: the driver queues the expected registered state per edge,
// and a monitor process pops and compares it shortly after each rising edge.
module tb_mux4to1_reg;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       sel;
    logic             valid;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in1, in2, in3, in4;
  logic [1:0]       sel;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic [1:0]       out_sel;
  logic [WIDTH-1:0] out_comb;

  int tests_run    = 0;
  int tests_failed = 0;

  exp_t exp_q[$];

  // Reference register state, updated in step with each stimulus vector.
  logic [WIDTH-1:0] model_data  = '0;
  logic [1:0]       model_sel   = 2'b00;
  logic             model_valid = 1'b0;

  mux4to1_reg #(
    .WIDTH(WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .in4(in4),
    .sel(sel),
    .in_valid(in_valid),
    .out(out),
    .out_valid(out_valid),
    .out_sel(out_sel),
    .out_comb(out_comb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_select(input logic [1:0] s, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c,
                                                  input logic [WIDTH-1:0] d);
    if (s == 2'd0) return a;
    if (s == 2'd1) return b;
    if (s == 2'd2) return c;
    return d;
  endfunction

  // Drive one vector on the falling edge, check the bypass, and queue the state due after the next rising edge.
  task automatic apply_stimulus(input logic r, input logic v, input logic [1:0] s,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                                input logic [WIDTH-1:0] exp_comb);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; sel = s;
    in1 = a; in2 = b; in3 = c; in4 = d;
    #1;
    check_output("out_comb", out_comb, exp_comb);
    if (r) begin
      model_data = '0; model_sel = 2'b00; model_valid = 1'b0;
    end else if (v) begin
      model_data = exp_comb; model_sel = s; model_valid = 1'b1;
    end else begin
      model_valid = 1'b0;
    end
    e.data = model_data; e.sel = model_sel; e.valid = model_valid;
    exp_q.push_back(e);
  endtask

  // Monitor: one popped entry per rising edge once the driver has started queueing.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_output("out_valid", {{(WIDTH-1){1'b0}}, out_valid}, {{(WIDTH-1){1'b0}}, e.valid});
        check_output("out_sel", {{(WIDTH-2){1'b0}}, out_sel}, {{(WIDTH-2){1'b0}}, e.sel});
        check_output("out", out, e.data);
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] a, b, c, d;
    logic [1:0]       s;
    rst = 1'b1; in_valid = 1'b0; sel = 2'b00;
    in1 = '0; in2 = '0; in3 = '0; in4 = '0;

    // Reset held two cycles while in_valid is high; bypass still follows sel.
    apply_stimulus(1, 1, 2'b10, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004, 32'hCCCC_0003);
    apply_stimulus(1, 1, 2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004, 32'hDDDD_0004);

    // Static sweep over all four codes.
    apply_stimulus(0, 1, 2'b00, 32'd2, 32'd5, 32'd8, 32'd15, 32'd2);
    apply_stimulus(0, 1, 2'b01, 32'd2, 32'd5, 32'd8, 32'd15, 32'd5);
    apply_stimulus(0, 1, 2'b10, 32'd2, 32'd5, 32'd8, 32'd15, 32'd8);
    apply_stimulus(0, 1, 2'b11, 32'd2, 32'd5, 32'd8, 32'd15, 32'd15);
    apply_stimulus(0, 1, 2'b10, 32'd2, 32'd5, 32'd8, 32'd15, 32'd8);

    // Hold: out stays 8 with sel 10 while the bypass shows the new in3.
    apply_stimulus(0, 0, 2'b10, 32'd2, 32'd5, 32'hFFFF_FFFF, 32'd15, 32'hFFFF_FFFF);
    apply_stimulus(0, 0, 2'b00, 32'd2, 32'd5, 32'hFFFF_FFFF, 32'd15, 32'd2);

    // MSB and LSB set on in4 only; zeros elsewhere must not leak.
    apply_stimulus(0, 1, 2'b11, 32'd0, 32'd0, 32'd0, 32'h8000_0001, 32'h8000_0001);
    apply_stimulus(0, 1, 2'b00, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF);

    // Mid-stream reset discards the in-flight word; next valid edge gives 5.
    apply_stimulus(0, 1, 2'b01, 32'd2, 32'd5, 32'd8, 32'd15, 32'd5);
    apply_stimulus(1, 1, 2'b01, 32'd2, 32'd7, 32'd8, 32'd15, 32'd7);
    apply_stimulus(0, 1, 2'b01, 32'd2, 32'd5, 32'd8, 32'd15, 32'd5);

    // Back-to-back: inputs and sel change every cycle.
    for (int i = 0; i < 16; i++) begin
      a = 32'h1000_0000 + 32'(i);
      b = 32'h2000_0000 ^ (32'(i) << 8);
      c = 32'hC000_0000 | (32'(i) * 32'h0101_0101);
      d = ~(32'h0F0F_0000 + 32'(i));
      s = 2'(i ^ (i >> 2));
      apply_stimulus(0, 1, s, a, b, c, d, ref_select(s, a, b, c, d));
    end

    // Final idle vector so the last captured word is checked as held.
    apply_stimulus(0, 0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

    @(posedge clk);
    #5;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mux4to1_reg.md
Name: mux4to1_reg

Overview:
- 4-input, WIDTH-bit selector with a registered output. `sel` picks one of `in1`..`in4`, and the chosen word appears on `out` one clock later.
- Used as a datapath source-select stage, e.g. to choose an operand or write-back value among four 32-bit buses.
- A combinational bypass output is also provided for consumers that cannot take the extra cycle.

Parameters:
- WIDTH, 32, data width of each input and of both outputs.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in1  input  WIDTH  data source 0, chosen when sel=2'b00.
- in2  input  WIDTH  data source 1, chosen when sel=2'b01.
- in3  input  WIDTH  data source 2, chosen when sel=2'b10.
- in4  input  WIDTH  data source 3, chosen when sel=2'b11.
- sel  input  2  source select.
- in_valid  input  1  qualifies sel and in1..in4 this cycle.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  registered; high when out holds data captured from a valid cycle.
- out_sel  output  2  registered copy of the sel value that produced out.
- out_comb  output  WIDTH  combinational selected data, zero latency.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All registered state updates only on the rising edge of clk.
- Select map is 00→in1, 01→in2, 10→in3, 11→in4. All four codes are decoded explicitly, so there is no default or illegal case.
- out_comb is a pure combinational function of sel and in1..in4, independent of clk, rst and in_valid.
- Reset: at a rising edge with rst=1, out=0, out_valid=0 and out_sel=2'b00. Reset takes priority over in_valid.
- Normal edge with rst=0 and in_valid=1:
  - out <= selected input.
  - out_sel <= sel.
  - out_valid <= 1.
  - Latency is exactly 1 cycle.
- Edge with rst=0 and in_valid=0: out and out_sel hold their previous values; out_valid <= 0.
- Throughput is one selection per cycle. There is no backpressure and no stall input.
- Changing sel or any input every cycle is legal; each edge captures that cycle's values independently.
- Reset asserted mid-stream: outputs clear on that edge, and the in-flight value is discarded. The first valid edge after rst deasserts produces data normally.
- Data is passed bit-exact, with no sign or width conversion. All WIDTH bits are carried, including MSB=1 patterns.
- No X-propagation masking is required.

Decomposition:
- Shared package mux4to1_pkg:
  - localparams SEL_IN1=2'b00, SEL_IN2=2'b01, SEL_IN3=2'b10, SEL_IN4=2'b11.
  - typedef sel_t as logic [1:0].
- One sub-module, mux4to1_comb: a parameterised combinational 4:1 select. It drives out_comb and feeds the output register in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 and arbitrary inputs → out=0, out_valid=0, out_sel=0. Release rst.
- Static sweep: in1=2, in2=5, in3=8, in4=15, in_valid=1; sel=00,01,10,11 on consecutive cycles → out_comb=2,5,8,15 immediately; out=2,5,8,15 one cycle later each; out_sel tracks with the same lag.
- Hold: after out=8 (sel=10), drive in_valid=0 and change in3 to 32'hFFFF_FFFF → out stays 8, out_valid=0, out_comb shows FFFF_FFFF.
- Width/MSB: in4=32'h8000_0001, sel=11, in_valid=1 → out=32'h8000_0001 next cycle; other inputs set to 0 do not leak.
- Mid-stream reset: stream sel=01 with in_valid=1, assert rst for 1 cycle → out=0 and out_valid=0 on that edge. Next valid edge gives out=5.
- Back-to-back: change in1..in4 and sel every cycle for 16 random cycles → out equals the reference selection of the previous cycle each edge.
